// File: rtl/fb_arbiter.sv
// fb_arbiter
//   Shares one single-port frame-buffer RAM between three users:
//     * the display scan-out, which owns the RAM in every visible in-range
//       cycle and is never stalled,
//     * a frame-clear engine that sweeps the whole buffer with one colour,
//     * a small write FIFO fed by a pixel writer.
//   Any cycle that is not a display slot is a free slot. The clear engine
//   gets it first, then the FIFO head. Otherwise the RAM is left idle.
//
// Ports
//   clk25MHz              sole clock, rising edge
//   rst                   asynchronous, active-high reset
//   pos_x, pos_y, active  scan position and visible flag from the timing generator
//   wr_valid / wr_ready   pixel write handshake
//   wr_x, wr_y, wr_color  pixel write payload
//   clr_req, clr_color    single-cycle clear request and its fill colour
//   clr_busy              clear sweep in progress
//   wr_drop               one-cycle pulse when an out-of-range write is discarded
//   mem_addr, mem_we,     registered RAM port
//   mem_wdata, mem_rdata
//   o_red, o_green, o_blue  registered pixel colour, two cycles behind the position
module fb_arbiter #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk25MHz,
  input  logic        rst,
  input  logic [8:0]  pos_x,
  input  logic [8:0]  pos_y,
  input  logic        active,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [8:0]  wr_x,
  input  logic [8:0]  wr_y,
  input  logic [2:0]  wr_color,
  input  logic        clr_req,
  input  logic [2:0]  clr_color,
  output logic        clr_busy,
  output logic        wr_drop,
  output logic [14:0] mem_addr,
  output logic        mem_we,
  output logic [2:0]  mem_wdata,
  input  logic [2:0]  mem_rdata,
  output logic        o_red,
  output logic        o_green,
  output logic        o_blue
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [8:0]       W_LIM    = 9'(FB_W);
  localparam logic [8:0]       H_LIM    = 9'(FB_H);
  localparam logic [14:0]      CLR_LAST = 15'(FB_W * FB_H - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Linear pixel address, no wrap: y*FB_W + x truncated to the RAM width.
  function automatic logic [14:0] pix_addr(input logic [8:0] x, input logic [8:0] y);
    return 15'(32'(y) * 32'(FB_W) + 32'(x));
  endfunction

  logic [0:0]       state;
  logic [14:0]      sweep;
  logic [2:0]       clr_col;

  logic [20:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             rdy_en;

  logic             disp_d1;
  logic             disp_d2;

  logic             disp_slot;
  logic             clr_slot;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [8:0]       head_x;
  logic [8:0]       head_y;
  logic [2:0]       head_c;
  logic             head_ok;

  // Write handshake: a write is transferred on every rising edge where
  // wr_valid and wr_ready are both 1. wr_valid may be raised without waiting
  // for wr_ready, and the payload must stay stable until the transfer edge.
  // wr_ready depends only on registered state, never on wr_valid.
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign wr_ready = rdy_en & ~full;
  assign push     = wr_valid & wr_ready;

  assign disp_slot = active && (pos_x < W_LIM) && (pos_y < H_LIM);
  assign clr_slot  = !disp_slot && (state == ST_CLEAR);
  // No pop on the clr_req edge either, so writes queued before a clear
  // land after it and are not overwritten by the sweep.
  assign pop       = !disp_slot && (state == ST_IDLE) && !clr_req && !empty;

  assign {head_x, head_y, head_c} = fifo_mem[rd_ptr];
  assign head_ok  = (head_x < W_LIM) && (head_y < H_LIM);
  assign clr_busy = (state == ST_CLEAR);

  // FIFO storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk25MHz) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {wr_x, wr_y, wr_color};
    end
  end

  always_ff @(posedge clk25MHz or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sweep     <= '0;
      clr_col   <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      rdy_en    <= 1'b0;
      wr_drop   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      disp_d1   <= 1'b0;
      disp_d2   <= 1'b0;
      o_red     <= 1'b0;
      o_green   <= 1'b0;
      o_blue    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;

      // Display pipeline: address registered at edge k, RAM data valid after
      // edge k+1, colour registered at edge k+2 gated by the delayed slot flag.
      disp_d1 <= disp_slot;
      disp_d2 <= disp_d1;
      o_red   <= disp_d2 & mem_rdata[2];
      o_green <= disp_d2 & mem_rdata[1];
      o_blue  <= disp_d2 & mem_rdata[0];

      // RAM port ownership for this slot.
      mem_we  <= 1'b0;
      wr_drop <= 1'b0;
      if (disp_slot) begin
        mem_addr <= pix_addr(pos_x, pos_y);
      end else if (clr_slot) begin
        mem_addr  <= sweep;
        mem_we    <= 1'b1;
        mem_wdata <= clr_col;
      end else if (pop) begin
        if (head_ok) begin
          mem_addr  <= pix_addr(head_x, head_y);
          mem_we    <= 1'b1;
          mem_wdata <= head_c;
        end else begin
          wr_drop <= 1'b1;
        end
      end

      // Clear FSM; a clr_req seen while already clearing is ignored.
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state   <= ST_CLEAR;
            clr_col <= clr_color;
            sweep   <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_slot) begin
            if (sweep == CLR_LAST) begin
              state <= ST_IDLE;
            end else begin
              sweep <= sweep + 15'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // FIFO pointers and occupancy.
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter FB_W, default 160: frame buffer width in pixels.
REQ-002 Parameter FB_H, default 120: frame buffer height in pixels.
REQ-003 Parameter FIFO_DEPTH, default 4: write request FIFO entries, power of two.
REQ-004 clk25MHz  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 pos_x, pos_y  in  9 each  current scan position from timing generator.
REQ-007 active  in  1  visible-area flag from timing generator.
REQ-008 wr_valid  in  1  writer presents a pixel write.
REQ-009 wr_ready  out  1  arbiter can accept a write.
REQ-010 wr_x, wr_y  in  9 each  write pixel coordinate.
REQ-011 wr_color  in  3  write colour {red, green, blue}.
REQ-012 clr_req  in  1  single-cycle pulse, start frame clear.
REQ-013 clr_color  in  3  fill colour, sampled with clr_req.
REQ-014 clr_busy  out  1  clear sweep in progress.
REQ-015 wr_drop  out  1  one-cycle pulse, out-of-range write discarded.
REQ-016 mem_addr  out  15  registered single-port RAM address.
REQ-017 mem_we  out  1  registered RAM write enable.
REQ-018 mem_wdata  out  3  registered RAM write data.
REQ-019 mem_rdata  in  3  RAM read data, valid one cycle after address edge.
REQ-020 o_red, o_green, o_blue  out  1 each  registered pixel colour.

Function
REQ-021 Address = pos_y*FB_W + pos_x (same formula for writes); width 15, no wrap.
REQ-022 Display slot: active=1 and pos_x<FB_W and pos_y<FB_H; display read owns RAM that cycle, mem_we=0.
REQ-023 Display latency: position sampled at edge k -> mem_addr at edge k -> colour on o_* after edge k+2.
REQ-024 o_* = 0 when delayed (2-cycle) display-slot flag is 0; otherwise o_* = mem_rdata bits.
REQ-025 Free slot (not display slot) priority: clear engine > write FIFO head > idle (mem_we=0).
REQ-026 FIFO push on wr_valid & wr_ready; wr_ready = !full; push and pop in same cycle leave count unchanged.
REQ-027 FIFO head with wr_x>=FB_W or wr_y>=FB_H: popped in next free slot, no RAM write, wr_drop=1 for one cycle.
REQ-028 State machine IDLE/CLEAR: IDLE -> CLEAR on clr_req (latch clr_color, sweep addr=0); clr_busy=1 in CLEAR.
REQ-029 CLEAR: each free slot writes latched colour to sweep addr, sweep addr+1; after writing FB_W*FB_H-1 -> IDLE same edge.
REQ-030 clr_req while in CLEAR is ignored; FIFO not popped in CLEAR but continues accepting until full.
REQ-031 Writes accepted before clr_req retire after the clear completes (clear wins ordering).
REQ-032 Display slots never stall; clear and FIFO progress only in free slots.

Reset
REQ-033 While rst=1: state IDLE, FIFO empty, wr_ready=0, clr_busy=0, wr_drop=0, mem_addr=0, mem_we=0, mem_wdata=0, o_*=0, delay pipeline cleared.
REQ-034 rst asserted mid-clear or mid-write aborts immediately; no further mem_we until new request; wr_ready=1 first edge after release.

Verification
REQ-035 active=0, push (x=5,y=2,color=3'b101) -> next edge mem_addr=325, mem_we=1, mem_wdata=3'b101.
REQ-036 Preload RAM addr 0=3'b100; active=1, pos=(0,0) at edge k -> o_red=1,o_green=0,o_blue=0 after edge k+2.
REQ-037 active=1 whole line in range, 5 pushes -> wr_ready=0 after 4th, mem_we=0 throughout; active=0 -> 4 writes on consecutive edges.
REQ-038 Push x=160,y=0 during blanking -> wr_drop pulse once, mem_we stays 0, FIFO empty after.
REQ-039 clr_req color=3'b010 with active=0 -> clr_busy for exactly 19200 cycles, addresses 0..19199 written 3'b010, second clr_req mid-sweep ignored.
REQ-040 rst pulse at sweep addr 100 -> mem_we=0, clr_busy=0 immediately; wr_ready=1 one edge after release.
